// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: synchronises the line, times start/data/stop sampling and
// hands completed frames to the consumer through a one-entry holding register.
module uart_rx_ctrl #(
    parameter int FRAME_WIDTH  = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_in,
    input  logic                   rx_ready,
    output logic [FRAME_WIDTH-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   busy,
    output logic                   frame_err,
    output logic                   overrun,
    output logic                   frame_dn
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [CW-1:0]          baud_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [FRAME_WIDTH-1:0] shift_q;
    logic [FRAME_WIDTH-1:0] shift_next;
    logic                   tick;
    logic                   load_half;
    logic                   load_full;
    logic                   shift_en;
    logic                   stop_good;
    logic                   stop_bad;
    logic                   accept;
    logic                   load_byte;

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign tick = (baud_cnt == '0);
    assign busy = (state != ST_IDLE);

    // Handshake: a byte moves to the consumer on any cycle with rx_valid & rx_ready;
    // rx_data is held stable while rx_valid is high and rx_ready is ignored otherwise.
    assign accept    = rx_valid & rx_ready;
    assign load_byte = stop_good & (~rx_valid | rx_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_half  = 1'b0;
        load_full  = 1'b0;
        shift_en   = 1'b0;
        stop_good  = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_next = ST_START;
                    load_half  = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (rx_s) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_DATA;
                        load_full  = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_en  = 1'b1;
                    load_full = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_next = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        stop_good  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        state_next = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // New bits enter at the MSB so the first bit received ends up in the LSB.
    always_comb begin
        shift_next                = shift_q >> 1;
        shift_next[FRAME_WIDTH-1] = rx_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '1;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_q   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_dn  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};

            if (load_half) begin
                baud_cnt <= HALF_LOAD;
            end else if (load_full) begin
                baud_cnt <= FULL_LOAD;
            end else if (!tick) begin
                baud_cnt <= baud_cnt - 1'b1;
            end

            if (state != ST_DATA) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (shift_en) begin
                shift_q <= shift_next;
            end

            // A byte arriving while the old one is accepted replaces it without a gap.
            if (load_byte) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
            end else if (accept) begin
                rx_valid <= 1'b0;
            end

            frame_dn  <= stop_good | stop_bad;
            frame_err <= stop_bad;
            overrun   <= stop_good & ~load_byte;
        end
    end

endmodule
